// File: rtl/data_buffer_pkg.sv
// -----------------------------------------------------------------------------
// data_buffer_pkg
// Purpose : Definitions shared by the data buffer controller and its arbiter:
//           FSM state encoding, default word width / frame depth (these match
//           the DUT_data_buffer data port and entry count), and a constant
//           ceil(log2) helper for sizing counters and index fields.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package data_buffer_pkg;

    localparam int BUF_DATA_W = 16;
    localparam int BUF_DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    // ceil(log2(n)), minimum 1 so that index fields are never zero width.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/data_buffer_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purpose : Combinational round-robin pick. Searches req starting one above
//           last_grant and wrapping modulo N_REQ; the first set bit wins, so
//           the previous winner has the lowest priority.
// Ports   : req        in  N_REQ  request vector, bit i = requester i
//           last_grant in  SRC_W  index of the most recently served requester
//           grant      out SRC_W  winning index (0 when any_req is low)
//           any_req    out 1      at least one request bit set
// -----------------------------------------------------------------------------
module rr_arbiter
    import data_buffer_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SRC_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] last_grant,
    output logic [SRC_W-1:0] grant,
    output logic             any_req
);

    logic [SRC_W-1:0] idx;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        // i runs 1..N_REQ so last_grant itself is examined last.
        for (int i = 1; i <= N_REQ; i++) begin
            idx = SRC_W'((int'(last_grant) + i) % N_REQ);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                grant   = idx;
            end
        end
    end

endmodule

// File: rtl/data_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// data_buffer_ctrl
// Purpose : Sequences DUT_data_buffer. Grants one of N_REQ word sources per
//           frame of DEPTH words, steers that source onto the buffer input and
//           pulses buf_start once per accepted word, then holds the completed
//           frame until downstream acknowledges it. Priority rotates after
//           each acknowledged frame.
// Ports   : clock        in   1             rising-edge clock
//           reset        in   1             synchronous, active-high
//           req_valid    in   N_REQ         per-requester word valid
//           req_data     in   N_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
//           req_ready    out  N_REQ         word taken when valid & ready
//           buf_start    out  1             buffer shifts buf_data in this edge
//           buf_data     out  DATA_W        word to buffer (0 when idle)
//           frame_valid  out  1             buffer holds a complete frame
//           frame_src    out  SRC_W         owner of current/last frame
//           frame_ack    in   1             frame consumed; only seen in HOLD
//           busy         out  1             FSM not in IDLE
//           fsm_state    out  2             FSM state, for observation
//
// Handshake: a word moves from requester i on a rising edge where
//           req_valid[i] & req_ready[i]; req_ready never depends on req_valid,
//           and a valid source may be held off indefinitely. frame_valid
//           stays high until the edge that samples frame_ack in HOLD.
// -----------------------------------------------------------------------------
module data_buffer_ctrl
    import data_buffer_pkg::*;
#(
    parameter int DATA_W = BUF_DATA_W,
    parameter int DEPTH  = BUF_DEPTH,
    parameter int N_REQ  = 4,
    parameter int SRC_W  = clog2(N_REQ)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    buf_start,
    output logic [DATA_W-1:0]       buf_data,
    output logic                    frame_valid,
    output logic [SRC_W-1:0]        frame_src,
    input  logic                    frame_ack,
    output logic                    busy,
    output state_t                  fsm_state
);

    localparam int CNT_W = clog2(DEPTH);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] arb_grant;
    logic             any_req;
    logic             beat;
    logic             last_beat;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any_req    (any_req)
    );

    // A stalled granted source simply produces no beat; nothing times out.
    assign beat      = (state == FILL) && req_valid[grant];
    assign last_beat = beat && (cnt == CNT_W'(DEPTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= '0;
            last_grant <= SRC_W'(N_REQ - 1);
            frame_src  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= arb_grant;
                        frame_src <= arb_grant;
                    end
                end
                FILL: begin
                    if (last_beat) begin
                        cnt <= '0;
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (frame_ack) begin
                        last_grant <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req)   state_next = FILL;
            FILL:    if (last_beat) state_next = HOLD;
            HOLD:    if (frame_ack) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        buf_start   = 1'b0;
        buf_data    = '0;
        if (state == FILL) begin
            req_ready = N_REQ'(1) << grant;
        end
        if (beat) begin
            buf_start = 1'b1;
            buf_data  = req_data[grant*DATA_W +: DATA_W];
        end
    end

    assign frame_valid = (state == HOLD);
    assign busy        = (state != IDLE);
    assign fsm_state   = state;

endmodule

// File: tb/tb_data_buffer_ctrl.sv
module tb_data_buffer_ctrl;
    import data_buffer_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int NR    = 4;
    localparam int SW    = 2;
    localparam int MEM   = 64;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_ready;
    logic             buf_start;
    logic [DW-1:0]    buf_data;
    logic             frame_valid;
    logic [SW-1:0]    frame_src;
    logic             frame_ack = 1'b0;
    logic             busy;
    state_t           fsm_state;

    data_buffer_ctrl #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .N_REQ  (NR),
        .SRC_W  (SW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .buf_start   (buf_start),
        .buf_data    (buf_data),
        .frame_valid (frame_valid),
        .frame_src   (frame_src),
        .frame_ack   (frame_ack),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // ---------------- sources, buffer model, scoreboard ----------------
    logic [DW-1:0]       src_mem [NR][MEM];
    int                  head [NR];
    int                  exp_head [NR];
    logic [NR-1:0]       src_en = '0;
    logic [DEPTH*DW-1:0] buf_model = '0;
    logic [DW-1:0]       exp_q[$];
    logic [DEPTH*DW-1:0] frame_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hc     = 0;
    int prev   = 0;
    logic [DEPTH*DW-1:0] saved;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe 1ns later, transfer on
    // the following rising edge.
    task automatic step(input logic ack = 1'b0, input logic rst = 1'b0);
        @(negedge clock);
        reset     = rst;
        frame_ack = ack;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = src_en[i] && (head[i] < MEM);
            req_data[i*DW +: DW] = req_valid[i] ? src_mem[i][head[i]] : DW'($urandom);
        end
        #1;
        if (buf_start === 1'b1) begin
            chk("sb_word_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                chk("buf_data", 128'(buf_data), 128'(exp_q.pop_front()));
            end
            buf_model = {buf_model[DEPTH*DW-DW-1:0], buf_data};
        end else begin
            chk("buf_data_idle", 128'(buf_data), 128'(0));
        end
        for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) head[i]++;
        end
        cyc++;
    endtask

    task automatic expect_words(input int s, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(src_mem[s][exp_head[s] + k]);
        exp_head[s] += n;
    endtask

    // First word ends up deepest: word k lands at slot DEPTH-1-k.
    task automatic expect_frame(input int s);
        logic [DEPTH*DW-1:0] f;
        f = '0;
        for (int k = 0; k < DEPTH; k++) f[DW*(DEPTH-1-k) +: DW] = src_mem[s][exp_head[s] + k];
        frame_q.push_back(f);
        expect_words(s, DEPTH);
    endtask

    task automatic check_hold(input int exp_src);
        chk("hold_frame_valid", 128'(frame_valid), 128'(1));
        chk("hold_frame_src", 128'(frame_src), 128'(exp_src));
        chk("hold_req_ready", 128'(req_ready), 128'(0));
        chk("hold_busy", 128'(busy), 128'(1));
        chk("hold_state", 128'(fsm_state), 128'(HOLD));
        chk("frame_expected", 128'(frame_q.size() != 0), 128'(1));
        if (frame_q.size() != 0) chk("frame_contents", 128'(buf_model), 128'(frame_q.pop_front()));
    endtask

    task automatic run_frame(input logic ack, input int exp_src, output int hold_cyc);
        int   starts;
        logic seen;
        starts = 0;
        seen   = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            step(ack);
            if (buf_start === 1'b1) starts++;
            if (frame_valid === 1'b1) seen = 1'b1;
        end
        chk("frame_reached", 128'(seen), 128'(1));
        chk("frame_word_count", 128'(starts), 128'(DEPTH));
        check_hold(exp_src);
        hold_cyc = cyc;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_buf_start", 128'(buf_start), 128'(0));
        chk("rst_buf_data", 128'(buf_data), 128'(0));
        chk("rst_frame_valid", 128'(frame_valid), 128'(0));
        chk("rst_frame_src", 128'(frame_src), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_state", 128'(fsm_state), 128'(IDLE));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < NR; i++) begin
            head[i]     = 0;
            exp_head[i] = 0;
            for (int j = 0; j < MEM; j++) src_mem[i][j] = {4'(i), 12'($urandom_range(0, 4095))};
        end

        // Reset state
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step();
        check_reset_outputs();

        // 1: single source, back-to-back words
        src_en = 4'b0001;
        expect_frame(0);
        step();
        chk("t1_arb_cycle_start", 128'(buf_start), 128'(0));
        chk("t1_arb_cycle_busy", 128'(busy), 128'(0));
        for (int k = 0; k < DEPTH; k++) begin
            step();
            chk("t1_start", 128'(buf_start), 128'(1));
            chk("t1_ready", 128'(req_ready), 128'(4'b0001));
        end
        step();
        check_hold(0);
        src_en = 4'b0000;
        step(1'b1);
        chk("t1_valid_in_ack_cycle", 128'(frame_valid), 128'(1));
        step();
        chk("t1_busy_after_ack", 128'(busy), 128'(0));
        chk("t1_frame_valid_dropped", 128'(frame_valid), 128'(0));

        // 2: round robin, everyone valid, immediate ack
        step(1'b0, 1'b1);
        src_en = 4'b1111;
        expect_frame(0);
        expect_frame(1);
        expect_frame(2);
        expect_frame(3);
        expect_frame(0);
        for (int f = 0; f < 5; f++) begin
            run_frame(1'b1, f % NR, hc);
            if (f > 0) chk("t2_period", 128'(hc - prev), 128'(DEPTH + 2));
            prev = hc;
        end
        src_en = 4'b0000;
        step();
        chk("t2_idle", 128'(busy), 128'(0));

        // 3: granted source stalls after 3 words; others valid but ignored
        src_en = 4'b0100;
        expect_frame(2);
        step();
        chk("t3_arb_cycle_busy", 128'(busy), 128'(0));
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_start_pre", 128'(buf_start), 128'(1));
        end
        src_en = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_stall_start", 128'(buf_start), 128'(0));
            chk("t3_stall_ready", 128'(req_ready), 128'(4'b0100));
            chk("t3_stall_state", 128'(fsm_state), 128'(FILL));
        end
        src_en = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_start_post", 128'(buf_start), 128'(1));
        end
        step();
        check_hold(2);

        // 4: ack withheld for 20 cycles, then ack pulse during next FILL
        saved  = buf_model;
        src_en = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t4_hold_valid", 128'(frame_valid), 128'(1));
            chk("t4_hold_ready", 128'(req_ready), 128'(0));
            chk("t4_hold_start", 128'(buf_start), 128'(0));
            chk("t4_buffer_frozen", 128'(buf_model), 128'(saved));
        end
        expect_frame(3);
        step(1'b1);
        step();
        chk("t4_arb_cycle_busy", 128'(busy), 128'(0));
        for (int k = 0; k < DEPTH; k++) begin
            step(k == 3);
            chk("t4_fill_start", 128'(buf_start), 128'(1));
            chk("t4_fill_ready", 128'(req_ready), 128'(4'b1000));
        end
        src_en = 4'b0000;
        step();
        check_hold(3);
        step(1'b1);
        step();
        chk("t4_idle", 128'(busy), 128'(0));

        // 5: reset after 4 words of a frame
        src_en = 4'b0001;
        expect_words(0, 4);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_start_pre", 128'(buf_start), 128'(1));
        end
        src_en = 4'b0000;
        step(1'b0, 1'b1);
        step();
        check_reset_outputs();
        src_en = 4'b0001;
        expect_frame(0);
        run_frame(1'b0, 0, hc);
        src_en = 4'b0000;
        step(1'b1);
        step();
        chk("t5_idle", 128'(busy), 128'(0));

        // 6: contention across the wrap point
        step(1'b0, 1'b1);
        src_en = 4'b1010;
        expect_frame(1);
        expect_frame(3);
        run_frame(1'b1, 1, hc);
        run_frame(1'b1, 3, hc);
        src_en = 4'b0000;
        step();
        chk("t6_idle", 128'(busy), 128'(0));

        chk("sb_words_drained", 128'(exp_q.size()), 128'(0));
        chk("sb_frames_drained", 128'(frame_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
